cohub_rr: RTL

- Parametrised next-generation coherence hub for the SoC.
- Connects PN coherent agents (port 0 = memory, 1 = SDC, 2 = MMU, further ports for extra cores/DMA).
- Each agent's request is broadcast as a snoop to every other port. The hub collects all snoop responses, merges their MESI states, and answers the requester.
- Adds per-port request queues, round-robin lock arbitration with hold, and MESI merging over all four states.

---
 rtl/cohub_pkg.sv | 37 +++
 rtl/cohub_queue.sv | 60 ++++++
 rtl/cohub_rr.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cohub_pkg.sv
// Shared types and helpers for the cohub_rr coherence hub.
package cohub_pkg;

  localparam int unsigned RQ_RW  = 8;
  localparam int unsigned RQ_TW  = 8;
  localparam int unsigned RQ_AW  = 64;
  localparam int unsigned PN_MAX = 8;

  // Encoding order makes the merge of two states a plain max().
  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef struct packed {
    logic [RQ_RW-1:0] id;
    logic [RQ_TW-1:0] trsc;
    logic [RQ_AW-1:0] addr;
  } rqst_t;

  // First requesting index at or after start, wrapping modulo n.
  function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] start,
                                         input logic [3:0] n);
    logic [3:0] idx;
    rr_next = start;
    for (int k = int'(PN_MAX) - 1; k >= 0; k--) begin
      if (4'(k) < n) begin
        idx = 4'(start) + 4'(k);
        if (idx >= n) idx = idx - n;
        if (req[idx[2:0]]) rr_next = idx[2:0];
      end
    end
  endfunction

endpackage

// File: rtl/cohub_queue.sv
// DEPTH-entry synchronous FIFO holding one port's pending requests.
module cohub_queue #(
  parameter int unsigned W     = 80,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [W-1:0]                   din_i,
  input  logic                           pop_i,
  output logic [W-1:0]                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           full_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push against a full queue is dropped even when a pop happens alongside.
  always_comb begin
    do_push = push_i && !full_q;
    do_pop  = pop_i && (cnt_q != '0);
    wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d    = do_pop ? ptr_inc(rd_q) : rd_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = full_q;

endmodule

// File: rtl/cohub_rr.sv
// Coherence hub: per-port request queues, snoop broadcast, MESI merge, RR lock.
// Optional snoop timeout (tmo_err port, TMO parameter) under COHUB_RR_TIMEOUT_EN.
module cohub_rr
  import cohub_pkg::*;
#(
  parameter int unsigned PN    = 3,
  parameter int unsigned RW    = 8,
  parameter int unsigned TW    = 8,
  parameter int unsigned AW    = 64,
  parameter int unsigned DEPTH = 2
`ifdef COHUB_RR_TIMEOUT_EN
  , parameter int unsigned TMO = 255
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PN-1:0]    s_lock,
  output logic [PN-1:0]    m_lock,
  input  logic [PN*RW-1:0] s_rqst,
  input  logic [PN*TW-1:0] s_trsc,
  input  logic [PN*AW-1:0] s_addr,
  output logic [PN-1:0]    s_full,
  output logic [PN*RW-1:0] s_resp,
  output logic [PN*2-1:0]  s_mesi,
  output logic [PN*RW-1:0] m_rqst,
  output logic [PN*TW-1:0] m_trsc,
  output logic [PN*AW-1:0] m_addr,
  input  logic [PN*RW-1:0] m_resp,
  input  logic [PN*2-1:0]  m_mesi,
  output logic [PN-1:0]    ovf
`ifdef COHUB_RR_TIMEOUT_EN
  , output logic [PN-1:0]  tmo_err
`endif
);

  localparam int unsigned QW = RW + TW + AW;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PN-1:0]    req_nz, q_full, q_pop, hv;
  logic [QW-1:0]    q_head [PN];
  logic [CW-1:0]    q_cnt  [PN];
  logic [RW-1:0]    h_id   [PN];
  logic [TW-1:0]    h_trsc [PN];
  logic [AW-1:0]    h_addr [PN];

  logic [PN-1:0]    sent_q [PN], sent_d [PN];
  logic [PN-1:0]    got_q  [PN], got_d  [PN];
  logic [PN-1:0]    iss    [PN];
  mesi_e            mrg_q  [PN], mrg_d  [PN];
  logic [PN*RW-1:0] resp_d;
  logic [PN*2-1:0]  smesi_d;
  logic [PN-1:0]    hit, gnx;
  mesi_e            mrg;
  logic             done, taken;

  logic [PN-1:0]    lock_d;
  logic [2:0]       ptr_q, ptr_d, gidx;

`ifdef COHUB_RR_TIMEOUT_EN
  localparam int unsigned TMW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  logic [TMW-1:0]   tmr_q [PN], tmr_d [PN];
  logic [PN-1:0]    tmo_d;
`endif

  for (genvar i = 0; i < PN; i++) begin : g_q
    assign req_nz[i] = (s_rqst[i*RW +: RW] != '0);
    assign hv[i]     = (q_cnt[i] != '0);
    assign h_id[i]   = q_head[i][QW-1 -: RW];
    assign h_trsc[i] = q_head[i][AW +: TW];
    assign h_addr[i] = q_head[i][AW-1:0];

    cohub_queue #(.W(QW), .DEPTH(DEPTH)) u_q (
      .clk     (clk),
      .rst     (rst),
      .push_i  (req_nz[i]),
      .din_i   ({s_rqst[i*RW +: RW], s_trsc[i*TW +: TW], s_addr[i*AW +: AW]}),
      .pop_i   (q_pop[i]),
      .head_o  (q_head[i]),
      .count_o (q_cnt[i]),
      .full_o  (q_full[i])
    );
  end

  assign s_full = q_full;

  // Each target gets the lowest-index head that has not yet snooped it.
  always_comb begin : snoop_issue
    m_rqst = '0;
    m_trsc = '0;
    m_addr = '0;
    taken  = 1'b0;
    for (int i = 0; i < PN; i++) iss[i] = '0;
    for (int j = 0; j < PN; j++) begin
      taken = 1'b0;
      for (int i = 0; i < PN; i++) begin
        if (!taken && hv[i] && !sent_q[i][j]) begin
          taken                = 1'b1;
          iss[i][j]            = 1'b1;
          m_rqst[j*RW +: RW]   = h_id[i];
          m_trsc[j*TW +: TW]   = h_trsc[i];
          m_addr[j*AW +: AW]   = h_addr[i];
        end
      end
    end
  end

  // Responses only count once the snoop to that target has gone out.
  always_comb begin : collect
    resp_d  = '0;
    smesi_d = '0;
    q_pop   = '0;
    hit     = '0;
    gnx     = '0;
    mrg     = MESI_I;
    done    = 1'b0;
`ifdef COHUB_RR_TIMEOUT_EN
    tmo_d   = '0;
`endif
    for (int i = 0; i < PN; i++) begin
      sent_d[i] = sent_q[i];
      got_d[i]  = got_q[i];
      mrg_d[i]  = mrg_q[i];
`ifdef COHUB_RR_TIMEOUT_EN
      tmr_d[i]  = tmr_q[i];
`endif
      hit = '0;
      mrg = mrg_q[i];
      for (int j = 0; j < PN; j++) begin
        if (hv[i] && sent_q[i][j] && (m_resp[j*RW +: RW] == h_id[i])) begin
          hit[j] = 1'b1;
          if (mesi_e'(m_mesi[j*2 +: 2]) > mrg) mrg = mesi_e'(m_mesi[j*2 +: 2]);
        end
      end
      gnx  = got_q[i] | hit;
      done = hv[i] && (&gnx);
`ifdef COHUB_RR_TIMEOUT_EN
      if (hv[i] && !(&gnx) && (tmr_q[i] == TMW'(TMO))) begin
        done     = 1'b1;
        mrg      = MESI_I;
        tmo_d[i] = 1'b1;
      end
`endif
      q_pop[i] = done;
      if (done) begin
        resp_d[i*RW +: RW] = h_id[i];
        smesi_d[i*2 +: 2]  = mrg;
      end
      if (!hv[i] || done) begin
        sent_d[i] = PN'(1) << i;
        got_d[i]  = PN'(1) << i;
        mrg_d[i]  = MESI_I;
`ifdef COHUB_RR_TIMEOUT_EN
        tmr_d[i]  = '0;
`endif
      end else begin
        sent_d[i] = sent_q[i] | iss[i];
        got_d[i]  = gnx;
        mrg_d[i]  = mrg;
`ifdef COHUB_RR_TIMEOUT_EN
        tmr_d[i]  = tmr_q[i] + TMW'(1);
`endif
      end
    end
  end

  // Holder keeps the grant; otherwise the pointer names the highest-priority port.
  always_comb begin : lock_arb
    lock_d = m_lock;
    ptr_d  = ptr_q;
    gidx   = rr_next(8'(s_lock), ptr_q, 4'(PN));
    if (!(|(m_lock & s_lock))) begin
      lock_d = '0;
      if (|s_lock) begin
        for (int p = 0; p < PN; p++) lock_d[p] = (3'(p) == gidx);
        ptr_d = (gidx == 3'(PN - 1)) ? 3'd0 : gidx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_lock <= '0;
      ptr_q  <= '0;
      s_resp <= '0;
      s_mesi <= '0;
      ovf    <= '0;
      for (int i = 0; i < PN; i++) begin
        sent_q[i] <= '0;
        got_q[i]  <= '0;
        mrg_q[i]  <= MESI_I;
      end
    end else begin
      m_lock <= lock_d;
      ptr_q  <= ptr_d;
      s_resp <= resp_d;
      s_mesi <= smesi_d;
      ovf    <= ovf | (req_nz & q_full);
      for (int i = 0; i < PN; i++) begin
        sent_q[i] <= sent_d[i];
        got_q[i]  <= got_d[i];
        mrg_q[i]  <= mrg_d[i];
      end
    end
  end

`ifdef COHUB_RR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_err <= '0;
      for (int i = 0; i < PN; i++) tmr_q[i] <= '0;
    end else begin
      tmo_err <= tmo_d;
      for (int i = 0; i < PN; i++) tmr_q[i] <= tmr_d[i];
    end
  end
`endif

endmodule
